// File: rtl/cva6_lsu_ctrl_model_pkg.sv
// Shared types and constants for the CVA6 load/store unit control model.
// The unit tracks store and load addresses only; no data is modelled.
package cva6_lsu_ctrl_model_pkg;

  localparam int ADDR_W             = 32;
  localparam int DEF_SPEC_DEPTH     = 4;
  localparam int DEF_COMMIT_DEPTH   = 4;
  localparam int DEF_OFFSET_LSB     = 2;
  localparam int DEF_OFFSET_MSB     = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STORE,
    REQ
  } load_state_e;

endpackage

// File: rtl/cva6_lsu_addr_fifo.sv
// Circular address FIFO with a parallel alias compare of every valid entry
// against a probe address.
module cva6_lsu_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] probe_i,
  input  logic             skip_head_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             alias_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_eff;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign head_o   = mem[rd_ptr_q];
  assign pop_eff  = pop_i && !empty_o;
  // A full queue still takes a push when its head leaves in the same cycle.
  assign push_eff = push_i && (!full_o || pop_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_eff)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem[wr_ptr_q] <= data_i;
  end

  // skip_head_i hides the head entry so callers can see post-pop contents.
  always_comb begin
    alias_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      int off;
      off = (i + DEPTH - int'(rd_ptr_q)) % DEPTH;
      if ((off < int'(count_q)) && !(skip_head_i && (off == 0)) && (mem[i] == probe_i))
        alias_o = 1'b1;
    end
  end

endmodule

// File: rtl/cva6_lsu_ctrl_model.sv
// Load/store unit control model: speculative and commit store queues plus a
// load FSM that stalls while any buffered store aliases the load address.
module cva6_lsu_ctrl_model
  import cva6_lsu_ctrl_model_pkg::*;
#(
  parameter int SPEC_DEPTH   = DEF_SPEC_DEPTH,
  parameter int COMMIT_DEPTH = DEF_COMMIT_DEPTH,
  parameter int OFFSET_LSB   = DEF_OFFSET_LSB,
  parameter int OFFSET_MSB   = DEF_OFFSET_MSB
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] instr_i,
  input  logic              is_load_i,
  input  logic              instr_valid_i,
  input  logic              store_commit_i,
  input  logic              store_mem_resp_i,
  input  logic              load_mem_resp_i,
  output logic              load_req_o,
  output logic              ready_o
);

  localparam int SLICE_W = OFFSET_MSB - OFFSET_LSB + 1;
  localparam logic [ADDR_W-1:0] SLICE_MASK = ADDR_W'(((64'd1 << SLICE_W) - 1) << OFFSET_LSB);

  load_state_e        state_q;
  logic [SLICE_W-1:0] load_addr_q;
  logic [SLICE_W-1:0] instr_slice;
  logic [SLICE_W-1:0] probe;
  logic [SLICE_W-1:0] spec_head;
  logic               spec_full, spec_empty, spec_alias;
  logic               commit_empty, commit_alias;
  logic               accept_store, accept_load, spec_pop, commit_pop, alias_any;
  logic [SLICE_W-1:0] unused_commit_head;
  logic               unused_commit_full;
  logic               unused_instr_bits;

  assign instr_slice       = instr_i[OFFSET_MSB:OFFSET_LSB];
  assign unused_instr_bits = ^(instr_i & ~SLICE_MASK);

  assign ready_o      = (state_q == IDLE) && !spec_full;
  assign accept_store = instr_valid_i && !is_load_i && ready_o;
  assign accept_load  = instr_valid_i && is_load_i && ready_o;
  assign spec_pop     = store_commit_i && !spec_empty;
  assign commit_pop   = store_mem_resp_i && !commit_empty;
  assign probe        = (state_q == IDLE) ? instr_slice : load_addr_q;
  assign alias_any    = spec_alias || commit_alias;

  cva6_lsu_addr_fifo #(.DEPTH(SPEC_DEPTH), .WIDTH(SLICE_W)) u_spec_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept_store),
    .pop_i       (spec_pop),
    .data_i      (instr_slice),
    .probe_i     (probe),
    .skip_head_i (1'b0),
    .full_o      (spec_full),
    .empty_o     (spec_empty),
    .head_o      (spec_head),
    .alias_o     (spec_alias)
  );

  // On load accept the retiring store is already gone from the alias view;
  // a committing store stays visible through the speculative queue head.
  cva6_lsu_addr_fifo #(.DEPTH(COMMIT_DEPTH), .WIDTH(SLICE_W)) u_commit_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (spec_pop),
    .pop_i       (commit_pop),
    .data_i      (spec_head),
    .probe_i     (probe),
    .skip_head_i ((state_q == IDLE) && commit_pop),
    .full_o      (unused_commit_full),
    .empty_o     (commit_empty),
    .head_o      (unused_commit_head),
    .alias_o     (commit_alias)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      load_req_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_load) begin
            load_addr_q <= instr_slice;
            state_q     <= alias_any ? WAIT_STORE : REQ;
            load_req_o  <= !alias_any;
          end
        end
        WAIT_STORE: begin
          if (!alias_any) begin
            state_q    <= REQ;
            load_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (load_mem_resp_i) begin
            state_q    <= IDLE;
            load_req_o <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          load_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_lsu_ctrl_model.sv
// Directed-vector bench for cva6_lsu_ctrl_model with hand-computed expectations.
module tb_cva6_lsu_ctrl_model;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        is_load;
  logic        instr_valid;
  logic        store_commit;
  logic        store_mem_resp;
  logic        load_mem_resp;
  logic        load_req;
  logic        ready;

  int vec_count  = 0;
  int fail_count = 0;

  cva6_lsu_ctrl_model dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_i          (instr),
    .is_load_i        (is_load),
    .instr_valid_i    (instr_valid),
    .store_commit_i   (store_commit),
    .store_mem_resp_i (store_mem_resp),
    .load_mem_resp_i  (load_mem_resp),
    .load_req_o       (load_req),
    .ready_o          (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vec_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then release them 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic ld, input logic [31:0] addr,
                               input logic cm, input logic sr, input logic lr);
    instr_valid    = v;
    is_load        = ld;
    instr          = addr;
    store_commit   = cm;
    store_mem_resp = sr;
    load_mem_resp  = lr;
    @(posedge clk);
    #1;
    instr_valid    = 1'b0;
    is_load        = 1'b0;
    instr          = 32'h0;
    store_commit   = 1'b0;
    store_mem_resp = 1'b0;
    load_mem_resp  = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0; is_load = 1'b0; instr_valid = 1'b0;
    store_commit = 1'b0; store_mem_resp = 1'b0; load_mem_resp = 1'b0;
    #3;
    checkOutput("reset_ready", ready, 1'b1);
    checkOutput("reset_load_req", load_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycle();

    // Plain load with no stores buffered
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("ld40_req", load_req, 1'b1);
    checkOutput("ld40_busy", ready, 1'b0);
    idleCycle();
    checkOutput("ld40_req_hold", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("ld40_done_req", load_req, 1'b0);
    checkOutput("ld40_done_ready", ready, 1'b1);

    // Load stalled behind a committed store to the same address
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("st40_ready", ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("alias_stall", load_req, 1'b0);
    checkOutput("alias_busy", ready, 1'b0);
    idleCycle();
    checkOutput("alias_stall2", load_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("retire_edge", load_req, 1'b0);
    idleCycle();
    checkOutput("retire_req", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("alias_done", ready, 1'b1);

    // Only the page-offset slice is compared
    applyStimulus(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h1080, 1'b0, 1'b0, 1'b0);
    checkOutput("slice_diff_req", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h1044, 1'b0, 1'b0, 1'b0);
    checkOutput("slice_same_stall", load_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("slice_same_req", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Fill the speculative queue
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill_ready_%0d", i), ready, (i < 3) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ignored", ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("commit_frees", ready, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h10C, 1'b0, 1'b0, 1'b0);
    checkOutput("drained_req", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a load
    applyStimulus(1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_req", load_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req", load_req, 1'b0);
    checkOutput("async_rst_ready", ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_empty", load_req, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_ready", ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cva6_lsu_ctrl_model.md
Name: cva6_lsu_ctrl_model

Overview:
- Cycle-level control model of the CVA6 load/store unit; tracks addresses only, no data.
- Sits under the processor-level verification shim. That shim issues one load or store address per operation, commits stores, and returns memory responses.
- Stores flow through a speculative queue, then a commit queue, and retire on memory acknowledge.
- Loads stall while any buffered store aliases their address. Loads then request memory and complete on response.

Parameters:
- SPEC_DEPTH, 4, speculative store queue entries.
- COMMIT_DEPTH, 4, committed store queue entries.
- OFFSET_LSB, 2, low bit of the compared address slice.
- OFFSET_MSB, 11, high bit of the compared address slice (page offset).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  32  byte address of the load/store being issued.
- is_load_i  in  1  1=load, 0=store; qualified by instr_valid_i.
- instr_valid_i  in  1  issue strobe; accepted only when ready_o=1.
- store_commit_i  in  1  commit the oldest speculative store.
- store_mem_resp_i  in  1  memory acknowledge for the oldest committed store.
- load_mem_resp_i  in  1  memory response for the outstanding load.
- load_req_o  out  1  load request to memory is pending.
- ready_o  out  1  unit can accept a new operation.

Behaviour:
- Reset (async assert): both queues empty; load FSM in IDLE; load_req_o=0; ready_o=1. Reset mid-operation discards all entries and any in-flight load immediately.
- ready_o (combinational) = (load FSM == IDLE) && speculative queue not full.
- instr_valid_i while ready_o=0 is ignored.
- Store accept:
  - instr_valid_i && !is_load_i && ready_o pushes instr_i into the speculative queue.
  - The entry is visible for alias checks the next cycle.
- Commit:
  - store_commit_i with a non-empty speculative queue pops its oldest entry and pushes it into the commit queue in the same edge.
  - Ignored if the speculative queue is empty.
  - Ignored if the commit queue is full and no store_mem_resp_i pop occurs that cycle; the upstream guarantees this does not happen.
- Store retire: store_mem_resp_i with a non-empty commit queue pops its oldest entry; ignored when empty.
- Simultaneous events:
  - Commit, retire and a new store push may all occur in one cycle. Occupancy updates use the net effect.
  - A push into a full queue is allowed when a pop occurs in the same cycle.
- Alias: a load aliases when instr_i[OFFSET_MSB:OFFSET_LSB] equals the same slice of any valid entry in either queue.
- Load FSM: IDLE, WAIT_STORE, REQ.
  - IDLE: accepted load latches its address. Next state is WAIT_STORE if it aliases (checked against queue contents after this cycle's updates), else REQ.
  - WAIT_STORE: re-evaluates alias every cycle; moves to REQ the cycle after no alias remains. A load aliasing a never-committed speculative store waits indefinitely; this is intended.
  - REQ: load_req_o=1. On load_mem_resp_i it returns to IDLE, so load_req_o=0 and ready_o=1 the next cycle.
- Latency: a non-aliasing load accepted at edge t has load_req_o=1 from t+1.
- load_mem_resp_i outside REQ is ignored.
- Address arithmetic: no wrap handling; only the compared slice matters.

Decomposition:
- Package cva6_lsu_ctrl_model_pkg holds:
  - the load FSM state enum (IDLE, WAIT_STORE, REQ);
  - default depths;
  - address width constant (32);
  - offset slice bounds.
- One sub-module, cva6_lsu_addr_fifo:
  - parameterised-depth address FIFO with push, pop, full and empty;
  - parallel alias-match output against a probe address;
  - instantiated twice (speculative and commit queues).

Test Plan:
- Reset asserted -> ready_o=1 and load_req_o=0 immediately; queues empty.
- Load 0x40, no stores:
  - load_req_o=1 next cycle and ready_o=0;
  - load_mem_resp_i pulse -> load_req_o=0 and ready_o=1 the following cycle.
- Store 0x40, commit, then load 0x40:
  - load_req_o stays 0 while the store is buffered;
  - store_mem_resp_i pulse -> load_req_o=1 one cycle later.
- Store 0x44 (committed, unacknowledged), then load 0x1080:
  - slices differ, so load_req_o=1 the next cycle;
  - a load to 0x1044 instead must stall.
- Four stores with no commit -> ready_o=0 after the 4th push; one store_commit_i -> ready_o=1 the next cycle.
- rst_i asserted while in REQ -> load_req_o=0 asynchronously; after release, ready_o=1 and no queue entries remain.
